// File: rtl/weight_buffer_arbiter.sv
// Shares the weight-buffer read port between the WFC (absolute priority) and a host readback port.
// Optional WBA_PERF_CNT_EN adds per-requester read counters (wfc_read_cnt, host_read_cnt).
module weight_buffer_arbiter #(
    parameter int MATRIX_WIDTH      = 14,
    parameter int BYTE_WIDTH        = 8,
    parameter int WEIGHT_ADDR_WIDTH = 16,
    parameter int READ_LATENCY      = 3,
    parameter int STARVE_LIMIT      = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 wfc_read_en,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]         wfc_addr,
    input  logic                                 host_req,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]         host_addr,
    output logic                                 host_gnt,
    output logic                                 host_rvalid,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]   host_rdata,
    output logic                                 host_starved,
    output logic                                 buf_read_en,
    output logic [WEIGHT_ADDR_WIDTH-1:0]         buf_addr,
    input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]   buf_rdata,
    output logic                                 busy
`ifdef WBA_PERF_CNT_EN
    ,
    output logic [31:0]                          wfc_read_cnt,
    output logic [31:0]                          host_read_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [READ_LATENCY-1:0] tag;
    logic [READ_LATENCY-1:0] tag_next;
    logic [CNT_W-1:0]        starve_cnt;

    always_comb begin
        host_gnt    = 1'b0;
        buf_read_en = 1'b0;
        buf_addr    = '0;
        if (wfc_read_en) begin
            buf_read_en = 1'b1;
            buf_addr    = wfc_addr;
        end else if (host_req && enable && !rst) begin
            buf_read_en = 1'b1;
            buf_addr    = host_addr;
            host_gnt    = 1'b1;
        end
    end

    always_comb begin
        tag_next    = '0;
        tag_next[0] = host_gnt;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_next[i] = tag[i-1];
        end
    end

    // buf_rdata is valid the cycle before a tag reaches the last stage,
    // so data is captured on the same edge that raises host_rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag          <= '0;
            host_rdata   <= '0;
            starve_cnt   <= '0;
            host_starved <= 1'b0;
        end else if (enable) begin
            tag <= tag_next;
            if (tag_next[READ_LATENCY-1]) begin
                host_rdata <= buf_rdata;
            end
            if (host_gnt || !host_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (host_gnt) begin
                host_starved <= 1'b0;
            end else if (host_req && (starve_cnt == LIMIT || starve_cnt == LIMIT - 1'b1)) begin
                host_starved <= 1'b1;
            end
        end
    end

    assign host_rvalid = tag[READ_LATENCY-1];
    assign busy        = |tag;

`ifdef WBA_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wfc_read_cnt  <= '0;
            host_read_cnt <= '0;
        end else if (enable) begin
            if (wfc_read_en) begin
                wfc_read_cnt <= wfc_read_cnt + 32'd1;
            end
            if (host_gnt) begin
                host_read_cnt <= host_read_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    logic                         prev_pending;
    logic [WEIGHT_ADDR_WIDTH-1:0] prev_addr;

    always_ff @(posedge clk) begin
        prev_pending <= host_req && !host_gnt && !rst;
        prev_addr    <= host_addr;
        if (prev_pending && host_req && host_addr != prev_addr) begin
            $warning("weight_buffer_arbiter: host_addr changed while host_req pending");
        end
    end
`endif

endmodule
